// File: rtl/fft_frame_ctrl_pkg.sv
// Shared definitions for the FFT frame controller.
//   state_t   : controller FSM encoding (IDLE, CFG, FEED, DRAIN)
//   MODE_FFT  : mode bit value selecting a forward transform
//   MODE_IFFT : mode bit value selecting an inverse transform
package fft_frame_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CFG   = 2'd1,
    ST_FEED  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam logic MODE_FFT  = 1'b1;
  localparam logic MODE_IFFT = 1'b0;

endpackage

// File: rtl/fft_pp_ram.sv
// Ping-pong result RAM: simple dual-port, registered read.
//   clk     : clock
//   wr_en   : write strobe
//   wr_addr : {bank, index} write address
//   wr_data : write word {im, re}
//   rd_addr : {bank, index} read address
//   rd_data : read word, valid one cycle after rd_addr
module fft_pp_ram #(
  parameter int unsigned AW = 11,
  parameter int unsigned W  = 64
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fft_frame_ctrl.sv
// FFT frame controller: configures a streaming FFT core, feeds it one frame
// of N samples from a source memory, and collects its results into a
// ping-pong RAM whose readable bank swaps at the end of every result frame.
//   i_clk, i_rstn                      : clock, async active-low reset
//   i_start, i_mode, o_busy            : frame request, 1=FFT/0=IFFT, busy
//   o_src_rd, o_src_addr, i_src_re/im  : source read port (1-cycle latency)
//   o_cfg_tvalid/tdata, i_cfg_tready   : core config channel
//   o_dat_tvalid/tdata/tlast, i_dat_tready : core input stream {im,re}
//   i_res_tvalid/tdata/tlast           : core result stream {im,re}
//   o_frame_done, o_len_err, o_bank    : swap pulse, sticky length error, bank
//   i_rd_addr, o_rd_data               : readback of the readable bank
module fft_frame_ctrl
  import fft_frame_ctrl_pkg::*;
#(
  parameter int unsigned LOG2N = 10,
  parameter int unsigned DW    = 16,
  parameter int unsigned OW    = 32,
  parameter int unsigned SHIFT = 10
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_start,
  input  logic              i_mode,
  output logic              o_busy,
  output logic              o_src_rd,
  output logic [LOG2N-1:0]  o_src_addr,
  input  logic [DW-1:0]     i_src_re,
  input  logic [DW-1:0]     i_src_im,
  output logic              o_cfg_tvalid,
  output logic              o_cfg_tdata,
  input  logic              i_cfg_tready,
  output logic              o_dat_tvalid,
  output logic [2*DW-1:0]   o_dat_tdata,
  output logic              o_dat_tlast,
  input  logic              i_dat_tready,
  input  logic              i_res_tvalid,
  input  logic [2*OW-1:0]   i_res_tdata,
  input  logic              i_res_tlast,
  output logic              o_frame_done,
  output logic              o_len_err,
  output logic              o_bank,
  input  logic [LOG2N-1:0]  i_rd_addr,
  output logic [2*OW-1:0]   o_rd_data
);

  state_t state, state_nxt;

  logic             mode_r;
  logic [LOG2N-1:0] feed_cnt;
  logic             feed_done;
  logic             inflight;
  logic             inflight_last;

  logic [2*DW-1:0]  skid0_data, skid1_data;
  logic             skid0_last, skid1_last;
  logic [1:0]       skid_cnt;

  logic [LOG2N-1:0] res_cnt;
  logic             res_done;
  logic             bank;
  logic             done_r;
  logic             len_err;

  logic             pop, issue, load_out, from_skid, inc_to_out, push_skid;
  logic [2:0]       occ;
  logic [DW-1:0]    inc_im;
  logic [2*DW-1:0]  inc_data;
  logic             frame_end;
  logic [OW-1:0]    wr_re, wr_im;

  // ---------------- feed path ----------------
  assign pop = o_dat_tvalid && i_dat_tready;

  // Occupancy left after this cycle's pop, counting the read already in
  // flight; total held never exceeds output register + 2 skid entries.
  assign occ   = 3'(o_dat_tvalid) + 3'(skid_cnt) + 3'(inflight) - 3'(pop);
  assign issue = (state == ST_FEED) && !feed_done && (occ < 3'd3);

  assign o_src_rd   = issue;
  assign o_src_addr = feed_cnt;

  assign load_out   = !o_dat_tvalid || pop;
  assign from_skid  = load_out && (skid_cnt != 2'd0);
  assign inc_to_out = load_out && (skid_cnt == 2'd0) && inflight;
  assign push_skid  = inflight && !inc_to_out;

  always_comb begin
    inc_im = i_src_im;
    if (mode_r == MODE_FFT) begin
      inc_im = '0;
    end
  end

  assign inc_data = {inc_im, i_src_re};

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      mode_r        <= MODE_IFFT;
      feed_cnt      <= '0;
      feed_done     <= 1'b0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      o_dat_tvalid  <= 1'b0;
      o_dat_tdata   <= '0;
      o_dat_tlast   <= 1'b0;
      skid0_data    <= '0;
      skid1_data    <= '0;
      skid0_last    <= 1'b0;
      skid1_last    <= 1'b0;
      skid_cnt      <= '0;
    end else begin
      if (state == ST_IDLE && i_start) begin
        mode_r    <= i_mode;
        feed_cnt  <= '0;
        feed_done <= 1'b0;
      end else if (issue) begin
        if (feed_cnt == '1) begin
          feed_done <= 1'b1;
        end else begin
          feed_cnt <= feed_cnt + 1'b1;
        end
      end

      inflight      <= issue;
      inflight_last <= issue && (feed_cnt == '1);

      if (load_out) begin
        if (skid_cnt != 2'd0) begin
          o_dat_tvalid <= 1'b1;
          o_dat_tdata  <= skid0_data;
          o_dat_tlast  <= skid0_last;
        end else if (inflight) begin
          o_dat_tvalid <= 1'b1;
          o_dat_tdata  <= inc_data;
          o_dat_tlast  <= inflight_last;
        end else begin
          o_dat_tvalid <= 1'b0;
          o_dat_tlast  <= 1'b0;
        end
      end

      // Skid is a 2-deep FIFO behind the output register; arrivals always
      // enter at the tail so beat order is preserved.
      unique case ({from_skid, push_skid})
        2'b10: begin
          skid0_data <= skid1_data;
          skid0_last <= skid1_last;
          skid_cnt   <= skid_cnt - 2'd1;
        end
        2'b01: begin
          if (skid_cnt == 2'd0) begin
            skid0_data <= inc_data;
            skid0_last <= inflight_last;
          end else begin
            skid1_data <= inc_data;
            skid1_last <= inflight_last;
          end
          skid_cnt <= skid_cnt + 2'd1;
        end
        2'b11: begin
          if (skid_cnt == 2'd1) begin
            skid0_data <= inc_data;
            skid0_last <= inflight_last;
          end else begin
            skid0_data <= skid1_data;
            skid0_last <= skid1_last;
            skid1_data <= inc_data;
            skid1_last <= inflight_last;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (i_start)             state_nxt = ST_CFG;
      ST_CFG:   if (i_cfg_tready)        state_nxt = ST_FEED;
      ST_FEED:  if (pop && o_dat_tlast)  state_nxt = ST_DRAIN;
      // Results may finish while still feeding; res_done remembers that.
      ST_DRAIN: if (frame_end || res_done) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign o_busy       = (state != ST_IDLE);
  assign o_cfg_tvalid = (state == ST_CFG);
  assign o_cfg_tdata  = mode_r;

  // ---------------- result path ----------------
  assign frame_end = i_res_tvalid && (i_res_tlast || (res_cnt == '1));

  assign wr_re = $signed(i_res_tdata[OW-1:0])    >>> SHIFT;
  assign wr_im = $signed(i_res_tdata[2*OW-1:OW]) >>> SHIFT;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      res_cnt  <= '0;
      res_done <= 1'b0;
      bank     <= 1'b0;
      done_r   <= 1'b0;
      len_err  <= 1'b0;
    end else begin
      done_r <= frame_end;
      if (frame_end) begin
        res_cnt <= '0;
        bank    <= ~bank;
        if (i_res_tlast != (res_cnt == '1)) begin
          len_err <= 1'b1;
        end
      end else if (i_res_tvalid) begin
        res_cnt <= res_cnt + 1'b1;
      end

      if (state == ST_IDLE && i_start) begin
        res_done <= 1'b0;
      end else if (frame_end) begin
        res_done <= 1'b1;
      end
    end
  end

  assign o_frame_done = done_r;
  assign o_len_err    = len_err;
  assign o_bank       = bank;

  // Read uses the pre-swap bank in the swap cycle, so readers see the old
  // frame until the edge after the swap.
  fft_pp_ram #(
    .AW (LOG2N + 1),
    .W  (2 * OW)
  ) u_ram (
    .clk     (i_clk),
    .wr_en   (i_res_tvalid),
    .wr_addr ({~bank, res_cnt}),
    .wr_data ({wr_im, wr_re}),
    .rd_addr ({bank, i_rd_addr}),
    .rd_data (o_rd_data)
  );

endmodule

// File: tb/tb_fft_frame_ctrl.sv
`timescale 1ns/1ps
module tb_fft_frame_ctrl;
  localparam int unsigned LOG2N = 4;
  localparam int unsigned N     = 16;
  localparam int unsigned DW    = 16;
  localparam int unsigned OW    = 32;
  localparam int unsigned SHIFT = 10;

  logic              i_clk = 1'b0;
  logic              i_rstn = 1'b0;
  logic              i_start = 1'b0;
  logic              i_mode = 1'b0;
  logic              o_busy;
  logic              o_src_rd;
  logic [LOG2N-1:0]  o_src_addr;
  logic [DW-1:0]     i_src_re, i_src_im;
  logic              o_cfg_tvalid, o_cfg_tdata;
  logic              i_cfg_tready = 1'b0;
  logic              o_dat_tvalid;
  logic [2*DW-1:0]   o_dat_tdata;
  logic              o_dat_tlast;
  logic              i_dat_tready = 1'b0;
  logic              i_res_tvalid = 1'b0;
  logic [2*OW-1:0]   i_res_tdata = '0;
  logic              i_res_tlast = 1'b0;
  logic              o_frame_done, o_len_err, o_bank;
  logic [LOG2N-1:0]  i_rd_addr = '0;
  logic [2*OW-1:0]   o_rd_data;

  always #5 i_clk = ~i_clk;

  fft_frame_ctrl #(.LOG2N(LOG2N), .DW(DW), .OW(OW), .SHIFT(SHIFT)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start), .i_mode(i_mode), .o_busy(o_busy),
    .o_src_rd(o_src_rd), .o_src_addr(o_src_addr), .i_src_re(i_src_re), .i_src_im(i_src_im),
    .o_cfg_tvalid(o_cfg_tvalid), .o_cfg_tdata(o_cfg_tdata), .i_cfg_tready(i_cfg_tready),
    .o_dat_tvalid(o_dat_tvalid), .o_dat_tdata(o_dat_tdata), .o_dat_tlast(o_dat_tlast),
    .i_dat_tready(i_dat_tready), .i_res_tvalid(i_res_tvalid), .i_res_tdata(i_res_tdata),
    .i_res_tlast(i_res_tlast), .o_frame_done(o_frame_done), .o_len_err(o_len_err),
    .o_bank(o_bank), .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data)
  );

  // Source memory model: data valid exactly one cycle after a read strobe.
  logic [DW-1:0]    src_re_mem [N];
  logic [DW-1:0]    src_im_mem [N];
  logic [LOG2N-1:0] src_q_addr = '0;
  logic             src_q_v = 1'b0;
  always @(posedge i_clk) begin
    src_q_addr <= o_src_addr;
    src_q_v    <= o_src_rd;
  end
  assign i_src_re = src_q_v ? src_re_mem[src_q_addr] : 16'hDEAD;
  assign i_src_im = src_q_v ? src_im_mem[src_q_addr] : 16'hBEEF;

  // Core-side monitor: records accepted beats, done pulses, stall violations.
  int              tot_beats = 0, tot_done = 0, stall_bad = 0;
  logic [2*DW-1:0] beat_data [256];
  logic            beat_last [256];
  logic            prev_stall = 1'b0;
  logic [2*DW-1:0] prev_data = '0;
  logic            prev_last = 1'b0;
  always @(negedge i_clk) begin
    if (!i_rstn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && !(o_dat_tvalid && o_dat_tdata == prev_data && o_dat_tlast == prev_last))
        stall_bad++;
      if (o_dat_tvalid && i_dat_tready) begin
        if (tot_beats < 256) begin
          beat_data[tot_beats] = o_dat_tdata;
          beat_last[tot_beats] = o_dat_tlast;
        end
        tot_beats++;
      end
      prev_stall = o_dat_tvalid && !i_dat_tready;
      prev_data  = o_dat_tdata;
      prev_last  = o_dat_tlast;
      if (o_frame_done) tot_done++;
    end
  end

  int vecs = 0, fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        mode;
    logic        toggle;
    logic        ramp;
    logic [31:0] re_base;
    logic [31:0] im_base;
    logic [31:0] exp_re;
    logic [31:0] exp_im;
    int          last_beat;   // beat carrying i_res_tlast; 16 = never
    logic        exp_err;
  } vec_t;

  vec_t        tab [5];
  logic [63:0] mdl [2][N];
  logic        mvalid [2][N];
  logic        mb = 1'b0;
  int          base_beats, base_done, base_stall;

  task automatic start_frame(input logic mode);
    base_beats = tot_beats;
    base_done  = tot_done;
    base_stall = stall_bad;
    @(posedge i_clk); #1;
    i_start = 1'b1; i_mode = mode;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    @(negedge i_clk); #1;
    check("cfg_state", {61'd0, o_busy, o_cfg_tvalid, o_cfg_tdata}, {61'd0, 1'b1, 1'b1, mode});
    @(posedge i_clk); #1;
    i_cfg_tready = 1'b1;
    @(posedge i_clk); #1;
    i_cfg_tready = 1'b0;
  endtask

  task automatic wait_beats(input int cnt, input logic toggle);
    logic got;
    got = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge i_clk); #1;
      if (tot_beats - base_beats >= cnt) begin
        got = 1'b1;
        break;
      end
      @(posedge i_clk); #1;
      i_dat_tready = toggle ? ~i_dat_tready : 1'b1;
    end
    check("feed_timeout", {63'd0, got}, 64'd1);
  endtask

  task automatic run_frame(input int idx, input vec_t t);
    int           nb;
    logic         old_v;
    logic [63:0]  old_d;
    logic [2*DW-1:0] exp_beat;
    for (int k = 0; k < N; k++) begin
      src_re_mem[k] = t.ramp ? 16'(k) : 16'($urandom);
      src_im_mem[k] = t.ramp ? 16'(16'hA5A5 + k) : 16'($urandom);
    end
    i_dat_tready = 1'b1;
    start_frame(t.mode);
    wait_beats(N, t.toggle);
    repeat (3) @(posedge i_clk);
    @(negedge i_clk); #1;
    check($sformatf("beat_count[%0d]", idx), 64'(tot_beats - base_beats), 64'(N));
    check($sformatf("drain_state[%0d]", idx), {61'd0, o_busy, o_dat_tvalid, o_src_rd}, 64'b100);
    check($sformatf("stall_hold[%0d]", idx), 64'(stall_bad - base_stall), 64'd0);
    for (int k = 0; k < N; k++) begin
      exp_beat = {(t.mode ? 16'h0000 : src_im_mem[k]), src_re_mem[k]};
      check($sformatf("beat[%0d][%0d]", idx, k),
            {31'd0, beat_last[base_beats + k], beat_data[base_beats + k]},
            {31'd0, (k == N - 1), exp_beat});
    end

    // Result frame; a stray i_start during DRAIN must be ignored.
    nb = (t.last_beat < int'(N)) ? t.last_beat + 1 : int'(N);
    old_v = 1'b0;
    old_d = '0;
    @(posedge i_clk); #1;
    i_rd_addr = '0;
    for (int k = 0; k < nb; k++) begin
      @(posedge i_clk); #1;
      i_res_tvalid = 1'b1;
      i_res_tdata  = {t.im_base + (32'(k) << 10), t.re_base + (32'(k) << 10)};
      i_res_tlast  = (k == t.last_beat);
      i_start      = (k == 3);
      if (k == nb - 1) begin
        old_v = mvalid[mb][0];
        old_d = mdl[mb][0];
      end
      mdl[~mb][k]    = {t.exp_im + 32'(k), t.exp_re + 32'(k)};
      mvalid[~mb][k] = 1'b1;
    end
    @(posedge i_clk); #1;
    i_res_tvalid = 1'b0;
    i_res_tlast  = 1'b0;
    i_start      = 1'b0;
    mb = ~mb;
    @(negedge i_clk); #1;
    check($sformatf("done_pulse[%0d]", idx), {63'd0, o_frame_done}, 64'd1);
    if (old_v) check($sformatf("rd_swap_old[%0d]", idx), o_rd_data, old_d);
    @(negedge i_clk); #1;
    check($sformatf("done_low[%0d]", idx), {63'd0, o_frame_done}, 64'd0);
    check($sformatf("rd_swap_new[%0d]", idx), o_rd_data, mdl[mb][0]);
    check($sformatf("end_state[%0d]", idx), {61'd0, o_busy, o_bank, o_len_err},
          {61'd0, 1'b0, mb, t.exp_err});
    check($sformatf("done_count[%0d]", idx), 64'(tot_done - base_done), 64'd1);
    for (int a = 0; a < N; a++) begin
      @(posedge i_clk); #1;
      i_rd_addr = LOG2N'(a);
      @(posedge i_clk);
      @(negedge i_clk); #1;
      if (mvalid[mb][a]) check($sformatf("readback[%0d][%0d]", idx, a), o_rd_data, mdl[mb][a]);
    end
  endtask

  task automatic reset_abort();
    i_dat_tready = 1'b1;
    start_frame(1'b1);
    wait_beats(5, 1'b0);
    @(posedge i_clk); #1;
    i_rstn = 1'b0;
    @(negedge i_clk); #1;
    check("abort_outs",
          {56'd0, o_busy, o_src_rd, o_cfg_tvalid, o_dat_tvalid, o_dat_tlast, o_frame_done, o_len_err, o_bank},
          64'd0);
    @(posedge i_clk); #1;
    i_rstn = 1'b1;
    mb = 1'b0;
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < N; a++) mvalid[b][a] = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk); #1;
    check("abort_no_done", {62'd0, o_busy, o_frame_done}, 64'd0);
    check("abort_done_count", 64'(tot_done - base_done), 64'd0);
  endtask

  initial begin
    //           mode  tgl   ramp  re_base        im_base        exp_re         exp_im         last err
    tab[0] = '{1'b1, 1'b0, 1'b1, 32'h0000_0400, 32'h0000_0800, 32'h0000_0001, 32'h0000_0002, 15, 1'b0};
    tab[1] = '{1'b0, 1'b1, 1'b0, 32'hFFFF_FC00, 32'h7FFC_0000, 32'hFFFF_FFFF, 32'h001F_FF00, 15, 1'b0};
    tab[2] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h1234_5400, 32'h0000_0000, 32'h0004_8D15, 16, 1'b1};
    tab[3] = '{1'b1, 1'b1, 1'b0, 32'h0000_0400, 32'h0000_0400, 32'h0000_0001, 32'h0000_0001, 10, 1'b1};
    tab[4] = '{1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_F3FF, 32'hFFE0_0000, 32'hFFFF_FFFC, 15, 1'b1};
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < N; a++) begin
        mvalid[b][a] = 1'b0;
        mdl[b][a]    = '0;
      end
    for (int k = 0; k < N; k++) begin
      src_re_mem[k] = '0;
      src_im_mem[k] = '0;
    end

    repeat (3) @(posedge i_clk);
    @(negedge i_clk); #1;
    check("reset_outs",
          {56'd0, o_busy, o_src_rd, o_cfg_tvalid, o_dat_tvalid, o_dat_tlast, o_frame_done, o_len_err, o_bank},
          64'd0);
    @(posedge i_clk); #1;
    i_rstn = 1'b1;

    for (int i = 0; i < 5; i++) begin
      if (i == 3) reset_abort();
      run_frame(i, tab[i]);
    end

    repeat (4) @(posedge i_clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule

// File: doc/fft_frame_ctrl.md
FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

Interface
REQ-001 SHALL have parameter LOG2N, default 10, log2 of frame length N (legal 4..12).
REQ-002 SHALL have parameter DW, default 16, input sample width per real/imag part.
REQ-003 SHALL have parameter OW, default 32, core result width per part.
REQ-004 SHALL have parameter SHIFT, default 10, arithmetic right shift applied to results (0..OW-1).
REQ-005 i_clk  in  1  clock; i_rstn  in  1  reset, asynchronous, active-low.
REQ-006 i_start  in  1  frame request pulse; i_mode  in  1  1=FFT, 0=IFFT; o_busy  out  1  frame in progress.
REQ-007 o_src_rd  out  1  source read strobe; o_src_addr  out  LOG2N  sample index; i_src_re, i_src_im  in  DW  sample, valid exactly 1 cycle after o_src_rd.
REQ-008 o_cfg_tvalid  out  1; o_cfg_tdata  out  1 (mode); i_cfg_tready  in  1: core config channel.
REQ-009 o_dat_tvalid  out  1; o_dat_tdata  out  2*DW {im,re}; o_dat_tlast  out  1; i_dat_tready  in  1: core input channel.
REQ-010 i_res_tvalid  in  1; i_res_tdata  in  2*OW {im,re}; i_res_tlast  in  1: core output channel, no backpressure.
REQ-011 o_frame_done  out  1  one-cycle pulse, bank swap; o_len_err  out  1  sticky length error; o_bank  out  1  readable bank index.
REQ-012 i_rd_addr  in  LOG2N; o_rd_data  out  2*OW  result of readable bank, registered.

Function
REQ-013 FSM states IDLE, CFG, FEED, DRAIN; reset state IDLE.
REQ-014 IDLE: i_start=1 latches i_mode, clears feed counter, goes CFG; i_start outside IDLE SHALL be ignored.
REQ-015 CFG: o_cfg_tvalid=1, o_cfg_tdata=latched mode; on i_cfg_tready=1 go FEED.
REQ-016 FEED: issue o_src_rd for addresses 0..N-1 in order; go DRAIN after transfer of beat with o_dat_tlast=1.
REQ-017 Read issue SHALL occur only when output register plus 2-entry skid buffer has space counting in-flight read; no sample lost or duplicated under any i_dat_tready pattern.
REQ-018 o_dat_tdata/o_dat_tvalid SHALL stay stable while o_dat_tvalid=1 and i_dat_tready=0.
REQ-019 o_dat_tlast=1 only on sample N-1; transfer = tvalid&tready.
REQ-020 In FFT mode im part sent as zero; in IFFT mode i_src_im passed through.
REQ-021 Back-to-back: with source and tready always 1, N beats in N consecutive cycles after first read latency.
REQ-022 DRAIN: each i_res_tvalid beat writes write-bank at result counter; counter wraps to 0 at N-1.
REQ-023 Stored value per part = i_res part arithmetically shifted right by SHIFT, sign-preserving, OW bits.
REQ-024 Result beat with i_res_tlast at counter N-1: swap banks (o_bank toggles), pulse o_frame_done next cycle, go IDLE.
REQ-025 i_res_tlast at counter != N-1, or counter reaching N-1 without tlast: set o_len_err, still swap and finish frame; counter resets.
REQ-026 Result beats accepted in any state (core latency may overlap FEED).
REQ-027 o_rd_data = readable bank[i_rd_addr] one cycle after address; write bank never readable.
REQ-028 o_busy=1 in all states except IDLE.
REQ-029 Simultaneous bank swap and read: read in the swap cycle returns old bank; next cycle returns new bank.

Reset
REQ-030 Reset: state IDLE, all counters 0, o_bank=0, o_busy=0, o_src_rd=0, o_cfg_tvalid=0, o_dat_tvalid=0, o_dat_tlast=0, o_frame_done=0, o_len_err=0, skid empty.
REQ-031 Reset mid-frame SHALL abort immediately; RAM contents undefined, no o_frame_done.
REQ-032 o_len_err cleared only by reset.

Structure
REQ-033 Shared package holds FSM state encoding and mode constants (MODE_FFT=1, MODE_IFFT=0).
REQ-034 One sub-module fft_pp_ram: simple dual-port RAM, depth 2*N, width 2*OW, address {bank,index}, registered read.

Verification
REQ-035 LOG2N=4, FFT, tready=1, i_src_re=addr -> 16 beats, re=0..15, im=0, tlast on beat 15, o_busy clear after DRAIN.
REQ-036 tready toggling 1010..., random src data -> core receives exact sequence, tdata stable in stalls, exactly 16 beats.
REQ-037 Result frame 16 beats value 0x400 each, SHIFT=10 -> readback 1 at all addresses, o_frame_done once, o_bank 0->1.
REQ-038 Result value 0xFFFFFC00 (-1024), SHIFT=10 -> readback 0xFFFFFFFF (-1).
REQ-039 tlast on beat 10 of 16 -> o_len_err=1, bank swaps, state IDLE; second frame normal, o_len_err stays 1.
REQ-040 i_rstn low during FEED beat 5 -> all outputs at reset values next cycle; new i_start completes a full frame.
